// File: rtl/inst_sequencer.sv
// Issues a small program of 31-bit instruction bodies as 32-bit inst words, with execute (bit 31)
// held for one full controller pass per instruction. Define SEQ_LOOP_EN to honour loop_i.
module inst_sequencer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = 4,
  parameter int unsigned EXEC_CYCLES = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_we_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [30:0]   load_data_i,
  input  logic [AW:0]   prog_len_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          loop_i,
  output logic [31:0]   inst_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] pc_o
);

  localparam int unsigned Hold = (EXEC_CYCLES < 6) ? 6 : EXEC_CYCLES;
  localparam int unsigned CW   = $clog2(Hold);

  typedef enum logic [1:0] {StIdle, StIssue, StGap, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [30:0]   body_q, body_d;
  logic [31:0]   inst_q, inst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] pc_out_q, pc_out_d;
  logic [30:0]   mem [DEPTH];
  logic          last_inst;

`ifndef SEQ_LOOP_EN
  logic unused_loop;
  assign unused_loop = loop_i;
`endif

  assign last_inst = ({1'b0, pc_q} == (len_q - (AW + 1)'(1)));

  // Program memory is not reset so it survives a mid-run reset.
  always_ff @(posedge clk_i) begin
    if (load_we_i && (state_q == StIdle || state_q == StDone)) begin
      mem[load_addr_i] <= load_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      pc_q     <= '0;
      len_q    <= '0;
      body_q   <= '0;
      inst_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      body_q   <= body_d;
      inst_q   <= inst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pc_out_q <= pc_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    len_d   = len_q;
    body_d  = body_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_i) begin
          if (prog_len_i != '0) begin
            len_d   = prog_len_i;
            pc_d    = '0;
            cnt_d   = '0;
            body_d  = mem[0];
            state_d = StIssue;
          end else begin
            state_d = StDone;
          end
        end
      end
      StIssue: begin
        if (cnt_q == CW'(Hold - 1)) begin
          cnt_d   = '0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StGap: begin
        if (last_inst) begin
          state_d = StDone;
`ifdef SEQ_LOOP_EN
          if (loop_i) begin
            pc_d    = '0;
            body_d  = mem[0];
            state_d = StIssue;
          end
`endif
        end else begin
          pc_d    = pc_q + AW'(1);
          body_d  = mem[pc_q + AW'(1)];
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      pc_d    = '0;
    end
  end

  // Outputs are registered from the current state, so they trail the state by one cycle.
  always_comb begin
    inst_d   = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    pc_out_d = pc_q;
    unique case (state_q)
      StIssue: begin
        inst_d = {1'b1, body_q};
        busy_d = 1'b1;
      end
      StGap: begin
        inst_d = {1'b0, body_q};
        busy_d = 1'b1;
      end
      StDone:  done_d = 1'b1;
      default: ;
    endcase
    if (abort_i) begin
      inst_d   = '0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      pc_out_d = '0;
    end
  end

  assign inst_o = inst_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign pc_o   = pc_out_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: a run-level model expands each program into the expected
// per-cycle output trace; a monitor pops and compares one record per cycle.
module tb_inst_sequencer;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned EXEC  = 6;
`ifdef SEQ_LOOP_EN
  localparam bit LoopEn = 1'b1;
`else
  localparam bit LoopEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]   inst;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [30:0]   load_data = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          loop = 1'b0;
  logic [31:0]   inst;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;

  logic [30:0]   prog [DEPTH];
  rec_t          exp_q[$];
  logic [AW-1:0] last_pc = '0;
  int            n_checks = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  inst_sequencer #(.DEPTH(DEPTH), .AW(AW), .EXEC_CYCLES(EXEC)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_we_i  (load_we),
    .load_addr_i(load_addr),
    .load_data_i(load_data),
    .prog_len_i (prog_len),
    .start_i    (start),
    .abort_i    (abort),
    .loop_i     (loop),
    .inst_o     (inst),
    .busy_o     (busy),
    .done_o     (done),
    .pc_o       (pc)
  );

  function automatic rec_t mk(input logic [31:0] i, input logic b, input logic d,
                              input logic [AW-1:0] p);
    rec_t r;
    r.inst = i;
    r.busy = b;
    r.done = d;
    r.pc   = p;
    return r;
  endfunction

  task automatic chk(input string name, input rec_t act, input rec_t exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got inst=%h busy=%b done=%b pc=%0d, want inst=%h busy=%b done=%b pc=%0d",
                  name, $time, act.inst, act.busy, act.done, act.pc,
                  exp.inst, exp.busy, exp.done, exp.pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk(32'h0, 1'b0, 1'b0, last_pc);
      chk("cycle", {inst, busy, done, pc}, e);
    end
  end

  task automatic load(input logic [AW-1:0] a, input logic [30:0] d);
    load_we = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_we = 1'b0;
    prog[a] = d;
  endtask

  // abort_at / wr_at / rst_at are edge offsets from the start-sampling edge (0 = unused).
  task automatic run(input int len, input bit lp, input int abort_at, input int wr_at,
                     input int rst_at);
    bit loop_eff;
    int budget;
    loop_eff = LoopEn && lp && (len > 0);
    prog_len = (AW + 1)'(len);
    loop = lp;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(mk(32'h0, 1'b0, 1'b0, last_pc));
    if (len == 0) begin
      exp_q.push_back(mk(32'h0, 1'b0, 1'b1, last_pc));
    end else begin
      for (int w = 0; w < (loop_eff ? 3 : 1); w++) begin
        for (int k = 0; k < len; k++) begin
          repeat (EXEC) exp_q.push_back(mk({1'b1, prog[k]}, 1'b1, 1'b0, AW'(k)));
          exp_q.push_back(mk({1'b0, prog[k]}, 1'b1, 1'b0, AW'(k)));
        end
      end
      if (!loop_eff) begin
        exp_q.push_back(mk(32'h0, 1'b0, 1'b1, AW'(len - 1)));
        last_pc = AW'(len - 1);
      end
    end
    if (wr_at > 0) begin
      repeat (wr_at - 1) tick();
      load_we = 1'b1;
      load_addr = '0;
      load_data = 31'h7FFF_FFFF;
      tick();
      load_we = 1'b0;
    end
    if (abort_at > 0) begin
      repeat (abort_at - 1) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp_q.delete();
      last_pc = '0;
    end
    if (rst_at > 0) begin
      repeat (rst_at - 1) tick();
      #2 rst_n = 1'b0;
      exp_q.delete();
      last_pc = '0;
      #1 chk("reset_async", {inst, busy, done, pc}, mk(32'h0, 1'b0, 1'b0, '0));
      repeat (2) tick();
      #2 rst_n = 1'b1;
    end
    budget = 2000;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      chk("drain_timeout", {inst, busy, done, pc}, mk(32'h0, 1'b0, 1'b0, last_pc));
      exp_q.delete();
    end
    loop = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    int len;
    int ab;
    bit lp;
    for (int i = 0; i < DEPTH; i++) prog[i] = '0;
    repeat (3) tick();
    chk("reset_state", {inst, busy, done, pc}, mk(32'h0, 1'b0, 1'b0, '0));
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) load(AW'(i), 31'(i * 3 + 1));
    load(0, 31'h0000_0021);
    load(1, 31'h0000_0442);
    load(2, 31'h0000_0863);

    run(3, 1'b0, 0, 0, 0);
    run(0, 1'b0, 0, 0, 0);
    run(3, 1'b0, 4, 0, 0);
    run(3, 1'b0, 0, 0, 0);
    run(3, 1'b0, 0, 5, 0);
    run(3, 1'b0, 0, 0, 0);
    run(3, 1'b0, 0, 0, 3);
    run(3, 1'b0, 0, 0, 0);
    if (LoopEn) run(2, 1'b1, 25, 0, 0);
    else run(2, 1'b1, 0, 0, 0);

    for (int it = 0; it < 15; it++) begin
      repeat ($urandom_range(0, 4)) load(AW'($urandom_range(0, DEPTH - 1)), 31'($urandom));
      len = $urandom_range(0, DEPTH);
      lp = 1'($urandom_range(0, 1));
      ab = 0;
      if (len > 0 && ((LoopEn && lp) || $urandom_range(0, 2) == 0))
        ab = $urandom_range(2, 7 * len - 1);
      run(len, lp, ab, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
